// File: rtl/mio_bus_responder_if.sv
// CPU-side memory port of the MIO responder: request strobes, address and
// store data from the core; load data, completion pulse and error back.
interface mio_bus_responder_if;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] M_addr;
    logic [31:0] data_out;
    logic [31:0] data2CPU;
    logic        MIO_ready;
    logic        bus_err;

    modport master (
        output req_rd, req_wr, M_addr, data_out,
        input  data2CPU, MIO_ready, bus_err
    );

    modport slave (
        input  req_rd, req_wr, M_addr, data_out,
        output data2CPU, MIO_ready, bus_err
    );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: RAM, LED/switch register and optional free-running
// counter (enabled by defining MIO_COUNTER_EN) behind a wait-stated handshake.
module mio_bus_responder #(
    parameter int RAM_AW      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mio_bus_responder_if.slave   bus,
    input  logic [7:0]           sw_in,
    output logic [7:0]           led_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RG_RAM  = 2'd0,
        RG_LED  = 2'd1,
        RG_CNT  = 2'd2,
        RG_NONE = 2'd3
    } region_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    // Word address (byte address >> 2) decode; the counter word is only
    // mapped when the counter is built in.
    function automatic region_e decode_region(input logic [31:2] a);
        if (a[31:28] == 4'h3) begin
            return RG_RAM;
        end else if (a == 30'h3C00_0000) begin
            return RG_LED;
`ifdef MIO_COUNTER_EN
        end else if (a == 30'h3C00_0001) begin
            return RG_CNT;
`endif
        end else begin
            return RG_NONE;
        end
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  led_q, led_d;
    logic [7:0]  sw_q;
    logic        ram_we_s;
    region_e     region_s;
    logic [31:0] rd_val_s;
    logic [31:0] cnt_rd_s;
    logic [31:0] mem_q [2**RAM_AW];

`ifdef MIO_COUNTER_EN
    logic [31:0] cnt_q;
    logic        cnt_we_s;

    // Free-running counter; a CPU write on the same edge takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'h0000_0000;
        end else if (cnt_we_s) begin
            cnt_q <= wdata_q;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_rd_s = cnt_q;
`else
    assign cnt_rd_s = 32'h0000_0000;
`endif

    assign region_s = decode_region(addr_q);

    // Read mux for the latched address
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (region_s)
            RG_RAM:  rd_val_s = mem_q[addr_q[RAM_AW+1:2]];
            RG_LED:  rd_val_s = {24'h00_0000, sw_q};
            RG_CNT:  rd_val_s = cnt_rd_s;
            default: rd_val_s = 32'h0000_0000;
        endcase
    end

    // Next-state and access logic; the access itself commits on the edge leaving ACCESS
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        led_d    = led_q;
        ram_we_s = 1'b0;
`ifdef MIO_COUNTER_EN
        cnt_we_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_rd || bus.req_wr) begin
                    addr_d  = bus.M_addr[31:2];
                    wdata_d = bus.data_out;
                    wr_d    = bus.req_wr;
                    wait_d  = WAIT_INIT;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    err_d   = (region_s == RG_NONE);
                    if (wr_q) begin
                        // Writes (including simultaneous rd+wr) return zero data
                        rdata_d = 32'h0000_0000;
                        case (region_s)
                            RG_RAM:  ram_we_s = 1'b1;
                            RG_LED:  led_d    = wdata_q[7:0];
`ifdef MIO_COUNTER_EN
                            RG_CNT:  cnt_we_s = 1'b1;
`endif
                            default: ram_we_s = 1'b0;
                        endcase
                    end else begin
                        rdata_d = rd_val_s;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
            addr_q  <= 30'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            led_q   <= 8'h00;
            sw_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            sw_q    <= sw_in;
        end
    end

    // RAM array is not reset; reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (ram_we_s && !reset) begin
            mem_q[addr_q[RAM_AW+1:2]] <= wdata_q;
        end
    end

    assign bus.data2CPU  = rdata_q;
    assign bus.MIO_ready = ready_q;
    assign bus.bus_err   = err_q;
    assign led_out       = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed self-checking bench for mio_bus_responder (WAIT_CYCLES=1 main
// instance plus a WAIT_CYCLES=0 instance for back-to-back timing).
module tb_mio_bus_responder;

    logic       clk;
    logic       reset;
    logic [7:0] sw_in;
    logic [7:0] led0, led1;
    int         n_tests;
    int         n_fail;

    mio_bus_responder_if if0 ();
    mio_bus_responder_if if1 ();

    mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .bus(if0), .sw_in(sw_in), .led_out(led0)
    );

    mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if1), .sw_in(sw_in), .led_out(led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE, returns at a negedge in the following IDLE cycle
    task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int lat);
        logic got;
        if0.req_rd   = rd;
        if0.req_wr   = wr;
        if0.M_addr   = addr;
        if0.data_out = wdata;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if0.MIO_ready) got = 1'b1;
            // Changing inputs mid-access must not disturb the latched request
            if0.M_addr   = 32'h5555_5555;
            if0.data_out = 32'hDEAD_BEEF;
        end
        rdata = if0.data2CPU;
        err   = if0.bus_err;
        if0.req_rd = 1'b0;
        if0.req_wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_one_cycle", {31'b0, if0.MIO_ready}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    int          pos[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        sw_in   = 8'h00;
        if0.req_rd = 1'b0; if0.req_wr = 1'b0; if0.M_addr = 32'h0; if0.data_out = 32'h0;
        if1.req_rd = 1'b0; if1.req_wr = 1'b0; if1.M_addr = 32'h0; if1.data_out = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, if0.MIO_ready}, 32'h0);
        check_eq("rst_err",   {31'b0, if0.bus_err},   32'h0);
        check_eq("rst_data",  if0.data2CPU,           32'h0);
        check_eq("rst_led",   {24'h0, led0},          32'h0);
        reset = 1'b0;
        @(negedge clk);

        // RAM write then read-back, latency 2+WAIT_CYCLES
        bus_xfer(1'b0, 1'b1, 32'h3000_0010, 32'h1234_5678, rd, er, lat);
        check_eq("wr_lat", lat, 3);
        check_eq("wr_err", {31'b0, er}, 32'h0);
        bus_xfer(1'b1, 1'b0, 32'h3000_0010, 32'h0, rd, er, lat);
        check_eq("rd_lat",  lat, 3);
        check_eq("rd_data", rd, 32'h1234_5678);
        check_eq("rd_err",  {31'b0, er}, 32'h0);

        // Switches / LEDs
        sw_in = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        bus_xfer(1'b1, 1'b0, 32'hF000_0000, 32'h0, rd, er, lat);
        check_eq("sw_read", rd, 32'h0000_00A5);
        check_eq("sw_err",  {31'b0, er}, 32'h0);
        bus_xfer(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FF3C, rd, er, lat);
        check_eq("led_write", {24'h0, led0}, 32'h0000_003C);

        // Simultaneous rd+wr is a write returning zero
        bus_xfer(1'b1, 1'b1, 32'h3000_0030, 32'hAAAA_5555, rd, er, lat);
        check_eq("rdwr_data", rd, 32'h0);
        bus_xfer(1'b1, 1'b0, 32'h3000_0030, 32'h0, rd, er, lat);
        check_eq("rdwr_stored", rd, 32'hAAAA_5555);

        // Unmapped
        bus_xfer(1'b1, 1'b0, 32'h5000_0000, 32'h0, rd, er, lat);
        check_eq("unmap_rd_data", rd, 32'h0);
        check_eq("unmap_rd_err",  {31'b0, er}, 32'h1);
        bus_xfer(1'b0, 1'b1, 32'h5000_0000, 32'h0BAD_0BAD, rd, er, lat);
        check_eq("unmap_wr_err", {31'b0, er}, 32'h1);
        check_eq("unmap_wr_led", {24'h0, led0}, 32'h0000_003C);
        bus_xfer(1'b1, 1'b0, 32'h3000_0010, 32'h0, rd, er, lat);
        check_eq("unmap_wr_ram", rd, 32'h1234_5678);

        // Counter: write 0xFFFFFFFE, read-back sees the wrapped count (=1)
`ifdef MIO_COUNTER_EN
        bus_xfer(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, er, lat);
        check_eq("cnt_wr_err", {31'b0, er}, 32'h0);
        bus_xfer(1'b1, 1'b0, 32'hF000_0004, 32'h0, rd, er, lat);
        check_eq("cnt_wrap", rd, 32'h0000_0001);
        check_eq("cnt_rd_err", {31'b0, er}, 32'h0);
`else
        bus_xfer(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, er, lat);
        check_eq("nocnt_wr_err", {31'b0, er}, 32'h1);
        bus_xfer(1'b1, 1'b0, 32'hF000_0004, 32'h0, rd, er, lat);
        check_eq("nocnt_rd", rd, 32'h0);
        check_eq("nocnt_rd_err", {31'b0, er}, 32'h1);
`endif

        // Reset on the commit edge of a write to 0x30000020
        bus_xfer(1'b0, 1'b1, 32'h3000_0020, 32'hCAFE_F00D, rd, er, lat);
        bus_xfer(1'b1, 1'b0, 32'h3000_0020, 32'h0, rd, er, lat);
        check_eq("pre_rst_data", rd, 32'hCAFE_F00D);
        if0.req_wr = 1'b1; if0.M_addr = 32'h3000_0020; if0.data_out = 32'h1111_1111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        if0.req_wr = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ready", {31'b0, if0.MIO_ready}, 32'h0);
        check_eq("mid_rst_data",  if0.data2CPU, 32'h0);
        check_eq("mid_rst_err",   {31'b0, if0.bus_err}, 32'h0);
        check_eq("mid_rst_led",   {24'h0, led0}, 32'h0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if0.MIO_ready) pulses++;
        end
        check_eq("mid_rst_no_ready", pulses, 0);
        bus_xfer(1'b1, 1'b0, 32'h3000_0020, 32'h0, rd, er, lat);
        check_eq("mid_rst_ram", rd, 32'hCAFE_F00D);

        // WAIT_CYCLES=0, request held continuously: ready in cycles 2,5,8,11
        if1.req_rd = 1'b1;
        if1.M_addr = 32'h3000_0000;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.MIO_ready) pos.push_back(c);
        end
        if1.req_rd = 1'b0;
        check_eq("b2b_count", pos.size(), 4);
        for (int k = 0; k < pos.size() && k < 4; k++) begin
            check_eq("b2b_pos", pos[k], 2 + 3 * k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
